alu_share_arbiter: RTL and testbench

//  Shares one 16-bit combinational CLA ALU (and/or/add/sub, c_out/overflow/zero) between two

---
 rtl/alu_share_arbiter_if.sv | 52 +++++
 rtl/alu_share_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_if
//   Bundles every handshake/bus signal of the shared-ALU arbiter.
//   slave  modport : arbiter side (drives ready/response/ALU-operand signals)
//   master modport : environment side (requesters, response consumers, ALU)
//   Signals:
//     reqN_valid/ready, reqN_a/_b/_op  : request handshakes (N = 0,1)
//     rspN_valid/ready                 : response handshakes
//     rsp_r, rsp_cout/overflow/zero    : shared captured result and flags
//     rsp_err                          : illegal-op flag
//     alu_a/_b/_op                     : registered operands to the ALU
//     alu_r, alu_cout/overflow/zero    : combinational ALU outputs
// -----------------------------------------------------------------------------
interface alu_share_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int OP_W  = 3
);
   logic             req0_valid, req0_ready;
   logic [WIDTH-1:0] req0_a, req0_b;
   logic [OP_W-1:0]  req0_op;
   logic             req1_valid, req1_ready;
   logic [WIDTH-1:0] req1_a, req1_b;
   logic [OP_W-1:0]  req1_op;
   logic             rsp0_valid, rsp0_ready;
   logic             rsp1_valid, rsp1_ready;
   logic [WIDTH-1:0] rsp_r;
   logic             rsp_cout, rsp_overflow, rsp_zero, rsp_err;
   logic [WIDTH-1:0] alu_a, alu_b;
   logic [OP_W-1:0]  alu_op;
   logic [WIDTH-1:0] alu_r;
   logic             alu_cout, alu_overflow, alu_zero;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp0_ready, rsp1_ready,
      input  alu_r, alu_cout, alu_overflow, alu_zero,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      output rsp_r, rsp_cout, rsp_overflow, rsp_zero, rsp_err,
      output alu_a, alu_b, alu_op
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp0_ready, rsp1_ready,
      output alu_r, alu_cout, alu_overflow, alu_zero,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      input  rsp_r, rsp_cout, rsp_overflow, rsp_zero, rsp_err,
      input  alu_a, alu_b, alu_op
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational ALU between two requesters with round-robin
//   priority. One operation in flight: IDLE (accept) -> EXEC (ALU settles on
//   registered operands) -> RESP (result/flags held until consumed) -> IDLE.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high reset
//     bus   : alu_share_arbiter_if.slave (requests, responses, ALU operands)
//   Optional feature macro: ALU_ARB_OPCHECK_EN
//     defined   : illegal op codes are accepted but bypass the ALU, answering
//                 one cycle later with rsp_r=0, flags 0, rsp_err=1
//     undefined : op codes pass unchecked, rsp_err tied 0
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int WIDTH     = 16,
   parameter int OP_W      = 3,
   parameter int PRIO_INIT = 0
) (
   input logic               clk,
   input logic               reset,
   alu_share_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t           state_q, state_d;
   logic             prio_q, prio_d;
   logic             grant_q, grant_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [OP_W-1:0]  alu_op_q, alu_op_d;
   logic [WIDTH-1:0] rsp_r_q, rsp_r_d;
   logic             rsp_cout_q, rsp_cout_d;
   logic             rsp_ovf_q, rsp_ovf_d;
   logic             rsp_zero_q, rsp_zero_d;

   logic             winner;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [OP_W-1:0]  sel_op;
   logic [1:0]       req_rdy, rsp_vld;

`ifdef ALU_ARB_OPCHECK_EN
   logic rsp_err_q, rsp_err_d;

   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return (op == OP_W'(0)) || (op == OP_W'(1)) ||
             (op == OP_W'(2)) || (op == OP_W'(6));
   endfunction
`endif

   // Only-valid requester wins; on a tie the priority holder wins.
   assign winner = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
   assign sel_a  = winner ? bus.req1_a  : bus.req0_a;
   assign sel_b  = winner ? bus.req1_b  : bus.req0_b;
   assign sel_op = winner ? bus.req1_op : bus.req0_op;

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      grant_d    = grant_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      rsp_r_d    = rsp_r_q;
      rsp_cout_d = rsp_cout_q;
      rsp_ovf_d  = rsp_ovf_q;
      rsp_zero_d = rsp_zero_q;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err_d  = rsp_err_q;
`endif
      req_rdy    = 2'b00;
      rsp_vld    = 2'b00;
      case (state_q)
         IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               req_rdy[winner] = 1'b1;
               grant_d         = winner;
`ifdef ALU_ARB_OPCHECK_EN
               if (!op_legal(sel_op)) begin
                  // Illegal op bypasses the ALU; operand regs keep last value.
                  rsp_r_d    = '0;
                  rsp_cout_d = 1'b0;
                  rsp_ovf_d  = 1'b0;
                  rsp_zero_d = 1'b0;
                  rsp_err_d  = 1'b1;
                  state_d    = RESP;
               end else begin
                  alu_a_d  = sel_a;
                  alu_b_d  = sel_b;
                  alu_op_d = sel_op;
                  state_d  = EXEC;
               end
`else
               alu_a_d  = sel_a;
               alu_b_d  = sel_b;
               alu_op_d = sel_op;
               state_d  = EXEC;
`endif
            end
         end
         EXEC: begin
            rsp_r_d    = bus.alu_r;
            rsp_cout_d = bus.alu_cout;
            rsp_ovf_d  = bus.alu_overflow;
            rsp_zero_d = bus.alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
            rsp_err_d  = 1'b0;
`endif
            state_d    = RESP;
         end
         RESP: begin
            rsp_vld[grant_q] = 1'b1;
            if (grant_q ? bus.rsp1_ready : bus.rsp0_ready) begin
               prio_d  = ~grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         prio_q     <= 1'(PRIO_INIT);
         grant_q    <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         rsp_r_q    <= '0;
         rsp_cout_q <= 1'b0;
         rsp_ovf_q  <= 1'b0;
         rsp_zero_q <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         grant_q    <= grant_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         rsp_r_q    <= rsp_r_d;
         rsp_cout_q <= rsp_cout_d;
         rsp_ovf_q  <= rsp_ovf_d;
         rsp_zero_q <= rsp_zero_d;
`ifdef ALU_ARB_OPCHECK_EN
         rsp_err_q  <= rsp_err_d;
`endif
      end
   end

   assign bus.req0_ready   = req_rdy[0];
   assign bus.req1_ready   = req_rdy[1];
   assign bus.rsp0_valid   = rsp_vld[0];
   assign bus.rsp1_valid   = rsp_vld[1];
   assign bus.rsp_r        = rsp_r_q;
   assign bus.rsp_cout     = rsp_cout_q;
   assign bus.rsp_overflow = rsp_ovf_q;
   assign bus.rsp_zero     = rsp_zero_q;
   assign bus.alu_a        = alu_a_q;
   assign bus.alu_b        = alu_b_q;
   assign bus.alu_op       = alu_op_q;
`ifdef ALU_ARB_OPCHECK_EN
   assign bus.rsp_err      = rsp_err_q;
`else
   assign bus.rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Directed bench for alu_share_arbiter. Provides a behavioural 16-bit ALU
//   on the interface and checks handshakes, latency, results and flags
//   against hand-computed values.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   alu_share_arbiter_if #(.WIDTH(16), .OP_W(3)) bus ();

   alu_share_arbiter #(.WIDTH(16), .OP_W(3), .PRIO_INIT(0)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: and/or/add/sub, carry, signed overflow, zero.
   logic [16:0] m_s;
   logic [15:0] m_r;
   logic        m_c, m_v;
   always_comb begin
      m_s = 17'd0;
      m_r = 16'd0;
      m_c = 1'b0;
      m_v = 1'b0;
      case (bus.alu_op)
         3'b000: m_r = bus.alu_a & bus.alu_b;
         3'b001: m_r = bus.alu_a | bus.alu_b;
         3'b010: begin
            m_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            m_r = m_s[15:0];
            m_c = m_s[16];
            m_v = (bus.alu_a[15] == bus.alu_b[15]) && (m_r[15] != bus.alu_a[15]);
         end
         3'b110: begin
            m_s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
            m_r = m_s[15:0];
            m_c = m_s[16];
            m_v = (bus.alu_a[15] != bus.alu_b[15]) && (m_r[15] != bus.alu_a[15]);
         end
         default: m_r = 16'd0;
      endcase
   end
   assign bus.alu_r        = m_r;
   assign bus.alu_cout     = m_c;
   assign bus.alu_overflow = m_v;
   assign bus.alu_zero     = (m_r == 16'd0);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic rdy(input int n);
      return (n != 0) ? bus.req1_ready : bus.req0_ready;
   endfunction

   function automatic logic rspv(input int n);
      return (n != 0) ? bus.rsp1_valid : bus.rsp0_valid;
   endfunction

   task automatic drive_req(input int n, input logic v, input logic [15:0] a,
                            input logic [15:0] b, input logic [2:0] op);
      if (n != 0) begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
      end else begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
      end
   endtask

   task automatic set_rsp_ready(input int n, input logic v);
      if (n != 0) bus.rsp1_ready = v;
      else        bus.rsp0_ready = v;
   endtask

   // Presents a request, waits (bounded) for acceptance, returns #2 after the
   // accept edge with that requester's valid dropped.
   task automatic issue(input int n, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op);
      int k = 0;
      drive_req(n, 1'b1, a, b, op);
      #1;
      while (!rdy(n) && k < 20) begin
         tick();
         k++;
      end
      chk("accept_timeout", 32'(k < 20), 32'd1);
      chk("ready_exclusive", 32'(bus.req0_ready && bus.req1_ready), 32'd0);
      tick();
      drive_req(n, 1'b0, a, b, op);
   endtask

   // Waits for the response, checks latency and fields, optionally stalls
   // rsp_ready low for 'hold' cycles, then consumes it.
   task automatic rsp_check(input int n, input logic [15:0] r, input logic c,
                            input logic v, input logic z, input logic e,
                            input int lat, input int hold);
      int l = 1;
      while (!rspv(n) && l < 10) begin
         tick();
         l++;
      end
      chk("latency", 32'(l), 32'(lat));
      chk("rsp_other_valid", 32'(rspv(1 - n)), 32'd0);
      chk("rsp_r", 32'(bus.rsp_r), 32'(r));
      chk("rsp_cout", 32'(bus.rsp_cout), 32'(c));
      chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(v));
      chk("rsp_zero", 32'(bus.rsp_zero), 32'(z));
      chk("rsp_err", 32'(bus.rsp_err), 32'(e));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", 32'(rspv(n)), 32'd1);
         chk("hold_r", 32'(bus.rsp_r), 32'(r));
         chk("hold_zero", 32'(bus.rsp_zero), 32'(z));
         chk("hold_no_accept", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
      end
      set_rsp_ready(n, 1'b1);
      tick();
      set_rsp_ready(n, 1'b0);
      chk("rsp_consumed", 32'(rspv(n)), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick();
   endtask

   initial begin
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

      // Reset state
      reset = 1'b1;
      #3;
      chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      chk("rst_rsp_r", 32'(bus.rsp_r), 32'd0);
      chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
      chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
      chk("rst_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
      do_reset();

      // 1: simple add on req0
      issue(0, 16'd1, 16'd2, 3'b010);
      chk("t1_exec_valid", 32'(bus.rsp0_valid), 32'd0);
      chk("t1_alu_a", 32'(bus.alu_a), 32'd1);
      chk("t1_alu_b", 32'(bus.alu_b), 32'd2);
      chk("t1_alu_op", 32'(bus.alu_op), 32'd2);
      rsp_check(0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);

      // 2: simultaneous requests, priority 0 after reset
      do_reset();
      drive_req(0, 1'b1, 16'd20000, 16'd14, 3'b010);
      drive_req(1, 1'b1, 16'd8, 16'd4, 3'b110);
      #1;
      chk("t2_r0_ready", 32'(bus.req0_ready), 32'd1);
      chk("t2_r1_ready", 32'(bus.req1_ready), 32'd0);
      tick();
      drive_req(0, 1'b0, 16'd0, 16'd0, 3'b000);
      chk("t2_r1_wait", 32'(bus.req1_ready), 32'd0);
      rsp_check(0, 16'd20014, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
      chk("t2_r1_next", 32'(bus.req1_ready), 32'd1);
      issue(1, 16'd8, 16'd4, 3'b110);
      rsp_check(1, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
      drive_req(0, 1'b1, 16'd1, 16'd1, 3'b010);
      drive_req(1, 1'b1, 16'd1, 16'd1, 3'b010);
      #1;
      chk("t2_prio_back_r0", 32'(bus.req0_ready), 32'd1);
      chk("t2_prio_back_r1", 32'(bus.req1_ready), 32'd0);
      drive_req(0, 1'b0, 16'd0, 16'd0, 3'b000);
      drive_req(1, 1'b0, 16'd0, 16'd0, 3'b000);
      tick();

      // 3: signed overflow on req1 (positive and negative)
      issue(1, 16'd30000, 16'd30000, 3'b010);
      rsp_check(1, 16'hEA60, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0);
      issue(1, 16'h8AD0, 16'h8AD0, 3'b010);
      rsp_check(1, 16'h15A0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0);

      // 4: and -> zero, response stalled 5 cycles while req1 waits
      drive_req(1, 1'b1, 16'd100, 16'd23, 3'b010);
      issue(0, 16'hFFFF, 16'h0000, 3'b000);
      rsp_check(0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5);
      chk("t4_r1_after_release", 32'(bus.req1_ready), 32'd1);
      issue(1, 16'd100, 16'd23, 3'b010);
      rsp_check(1, 16'd123, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);

      // 5: reset during EXEC of req1 'or'
      issue(0, 16'hFFFF, 16'h0001, 3'b010);
      rsp_check(0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2, 0);
      issue(1, 16'd5, 16'd3, 3'b001);
      chk("t5_exec_alu_a", 32'(bus.alu_a), 32'd5);
      #1 reset = 1'b1;
      #1;
      chk("t5_rst_alu_a", 32'(bus.alu_a), 32'd0);
      chk("t5_rst_alu_b", 32'(bus.alu_b), 32'd0);
      chk("t5_rst_alu_op", 32'(bus.alu_op), 32'd0);
      chk("t5_rst_rsp_r", 32'(bus.rsp_r), 32'd0);
      chk("t5_rst_cout", 32'(bus.rsp_cout), 32'd0);
      chk("t5_rst_zero", 32'(bus.rsp_zero), 32'd0);
      chk("t5_rst_rsp1", 32'(bus.rsp1_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5_no_rsp1", 32'(bus.rsp1_valid), 32'd0);
      end
      drive_req(1, 1'b1, 16'd2, 16'd2, 3'b010);
      drive_req(0, 1'b1, 16'd10, 16'd10, 3'b110);
      #1;
      chk("t5_prio_r0", 32'(bus.req0_ready), 32'd1);
      chk("t5_prio_r1", 32'(bus.req1_ready), 32'd0);
      issue(0, 16'd10, 16'd10, 3'b110);
      drive_req(1, 1'b0, 16'd0, 16'd0, 3'b000);
      rsp_check(0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 0);

`ifdef ALU_ARB_OPCHECK_EN
      // 6: illegal op bypasses the ALU
      issue(0, 16'd7, 16'd9, 3'b011);
      chk("t6_alu_a_kept", 32'(bus.alu_a), 32'd10);
      chk("t6_alu_op_kept", 32'(bus.alu_op), 32'd6);
      rsp_check(0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
      issue(0, 16'd3, 16'd4, 3'b001);
      rsp_check(0, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
